// File: rtl/vproc_pkg.sv
// Shared vector-processor types: register-file write request payload and
// default datapath widths.
package vproc_pkg;

    localparam int unsigned VREG_W_DEF   = 128;
    localparam int unsigned DIV_OP_W_DEF = 64;

    typedef struct packed {
        logic [4:0]                addr;
        logic [VREG_W_DEF-1:0]     data;
        logic [VREG_W_DEF/8-1:0]   be;
    } vreg_wr_req_t;

endpackage

// File: rtl/vproc_div_res_writer.sv
// DIV result writer: packs DIV_OP_W result chunks into full vector-register
// writes with byte enables and reports when an instruction's last write lands.
module vproc_div_res_writer
    import vproc_pkg::*;
#(
    parameter int unsigned DIV_OP_W       = DIV_OP_W_DEF,
    parameter int unsigned VREG_W         = VREG_W_DEF,
    parameter bit          DONT_CARE_ZERO = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  sync_rst_ni,

    input  logic                  res_valid_i,
    output logic                  res_ready_o,
    input  logic [4:0]            res_vaddr_i,
    input  logic                  res_last_i,
    input  logic [DIV_OP_W-1:0]   res_data_i,
    input  logic [DIV_OP_W/8-1:0] res_mask_i,

    output logic                  vreg_wr_valid_o,
    input  logic                  vreg_wr_ready_i,
    output logic [4:0]            vreg_wr_addr_o,
    output logic [VREG_W-1:0]     vreg_wr_data_o,
    output logic [VREG_W/8-1:0]   vreg_wr_be_o,

    output logic                  instr_done_o
);

    localparam int unsigned N          = VREG_W / DIV_OP_W;
    localparam int unsigned CNT_W      = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BE_W       = VREG_W / 8;
    localparam int unsigned CHUNK_BE_W = DIV_OP_W / 8;

    typedef enum logic {
        FILL,
        WRITE
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [VREG_W-1:0]     buf_data;
    logic [BE_W-1:0]       buf_be;
    logic [4:0]            buf_addr;
    logic                  buf_last;
    logic                  addr_change;

    // A chunk for a different register arrives while a partial buffer is open.
    assign addr_change = (cnt != '0) & res_valid_i & (res_vaddr_i != buf_addr);
    assign res_ready_o = (state == FILL) & ~addr_change;

    assign vreg_wr_addr_o = buf_addr;
    assign vreg_wr_data_o = buf_data;
    assign vreg_wr_be_o   = buf_be;

    always_ff @(posedge clk_i) begin
        if (!sync_rst_ni) begin
            state           <= FILL;
            cnt             <= '0;
            buf_be          <= '0;
            buf_last        <= 1'b0;
            vreg_wr_valid_o <= 1'b0;
            instr_done_o    <= 1'b0;
            if (DONT_CARE_ZERO) begin
                buf_data <= '0;
            end
        end else begin
            instr_done_o <= 1'b0;
            case (state)
                FILL: begin
                    if (addr_change) begin
                        // Flush the partial buffer; the pending chunk waits.
                        cnt             <= '0;
                        buf_last        <= 1'b0;
                        state           <= WRITE;
                        vreg_wr_valid_o <= 1'b1;
                    end else if (res_valid_i) begin
                        buf_data[DIV_OP_W*cnt +: DIV_OP_W]   <= res_data_i;
                        buf_be[CHUNK_BE_W*cnt +: CHUNK_BE_W] <= res_mask_i;
                        buf_addr                             <= res_vaddr_i;
                        buf_last                             <= res_last_i;
                        if ((cnt == CNT_W'(N - 1)) || res_last_i) begin
                            cnt             <= '0;
                            state           <= WRITE;
                            vreg_wr_valid_o <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                WRITE: begin
                    if (vreg_wr_ready_i) begin
                        state           <= FILL;
                        vreg_wr_valid_o <= 1'b0;
                        buf_be          <= '0;
                        instr_done_o    <= buf_last;
                        buf_last        <= 1'b0;
                        if (DONT_CARE_ZERO) begin
                            buf_data <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule
